// File: rtl/sct_addr_rx.sv
// Serial receiver for the sector-address frame: start bit, DATA_BITS data bits MSB first,
// stop bit. Each bit is sampled at mid-bit; only correctly framed addresses are presented.
module sct_addr_rx #(
   parameter int CLKS_PER_BIT = 480,
   parameter int DATA_BITS    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_uart,
   output logic [DATA_BITS-1:0] sct_addr,
   output logic                 addr_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_TOP   = IW'(DATA_BITS - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;

   logic                 sync1;
   logic                 rxs;
   logic [2:0]           state;
   logic [CW-1:0]        bit_cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shift;

   // Line is asynchronous to clk; both stages reset high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= in_uart;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         idx        <= '0;
         shift      <= '0;
         sct_addr   <= '0;
         addr_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults here are overridden later in the same block,
         // which is how the strobes become single-cycle pulses without extra logic.
         addr_valid <= 1'b0;
         frame_err  <= 1'b0;
         bit_cnt    <= bit_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state   <= START;
                  bit_cnt <= '0;
               end
            end
            START: begin
               // Re-check the line at mid start bit to reject glitches.
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt <= '0;
                  if (!rxs) begin
                     state <= DATA;
                     idx   <= IDX_TOP;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt    <= '0;
                  shift[idx] <= rxs;
                  if (idx == '0) state <= STOP;
                  else           idx   <= idx - 1'b1;
               end
            end
            STOP: begin
               // Sampled at mid stop bit, so IDLE is reached half a bit before the next start.
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (rxs) begin
                     sct_addr   <= shift;
                     addr_valid <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end
            end
            BREAK: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
